// File: rtl/i2c_master_byte_engine.sv
// i2c_master_byte_engine: Avalon-MM I2C master moving one byte per command (START, 8 bits + ACK, STOP).
// Optional completion interrupt: define I2C_MASTER_IRQ_EN.
module i2c_master_byte_engine #(
   parameter int unsigned DIV_RESET = 124,
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        scl_oe,
   output logic        sda_oe,
`ifdef I2C_MASTER_IRQ_EN
   output logic        irq,
`endif
   input  logic        scl_in,
   input  logic        sda_in
);
   typedef enum logic [2:0] {IDLE, START_A, START_B, BIT, STOP_A, STOP_B, STOP_C} state_t;
   state_t state_q, state_d;
   logic [3:0] bit_q, bit_d;
   logic [1:0] phase_q, phase_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q;
   logic [7:0] tx_q, rx_q;
   logic [3:0] cmd_q;
   logic [31:0] readdata_q, readdata_d;
   logic [2:0] tx_idx;
   logic busy_q, done_q, nack_q, hold_q, hold_d, ie_q;
   logic wr, go, released, stall, tick, fin, samp, bit_sda, unused_ok;
   assign wr = chipselect && !write_n;
   assign go = wr && address == 2'd1 && writedata[4] && !busy_q;
   assign released = state_q inside {START_A, START_B, STOP_B, STOP_C} || (state_q == BIT && phase_q[1]);
   // a slave holding SCL low freezes the quarter counter until the line actually rises
   assign stall = released && !scl_in;
   assign tick = state_q != IDLE && cnt_q == '0 && !stall;
   assign cnt_d = state_q == IDLE || tick ? div_q : stall ? cnt_q : cnt_q - DIV_WIDTH'(1);
   assign fin = state_q != IDLE && state_d == IDLE;
   assign samp = tick && state_q == BIT && phase_q == 2'd2;
   assign tx_idx = 3'(bit_q - 4'd1);
   assign bit_sda = bit_q == 4'd0 ? cmd_q[2] && !cmd_q[3] : !cmd_q[2] && !tx_q[tx_idx];
   // a byte finished without STOP keeps SCL low so the bus stays owned
   assign hold_d = fin ? state_q == BIT : hold_q;
   assign unused_ok = ^writedata;
   assign readdata = readdata_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bit_q <= '0;
         phase_q <= '0;
         cnt_q <= DIV_WIDTH'(DIV_RESET);
         hold_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q <= bit_d;
         phase_q <= phase_d;
         cnt_q <= cnt_d;
         hold_q <= hold_d;
      end
   end
   always_comb begin
      state_d = state_q;
      bit_d = bit_q;
      phase_d = phase_q;
      if (state_q == IDLE) begin
         if (go) begin
            state_d = writedata[0] ? START_A : BIT;
            bit_d = 4'd8;
            phase_d = 2'd0;
         end
      end else if (tick) begin
         case (state_q)
            START_A: state_d = START_B;
            START_B: begin
               state_d = BIT;
               bit_d = 4'd8;
               phase_d = 2'd0;
            end
            BIT: begin
               phase_d = phase_q + 2'd1;
               if (phase_q == 2'd3) begin
                  bit_d = bit_q - 4'd1;
                  if (bit_q == 4'd0) state_d = cmd_q[1] ? STOP_A : IDLE;
               end
            end
            STOP_A: state_d = STOP_B;
            STOP_B: state_d = STOP_C;
            default: state_d = IDLE;
         endcase
      end
   end
   always_comb begin
      scl_oe = state_q == IDLE ? hold_q : state_q == BIT ? !phase_q[1] : state_q == STOP_A;
      sda_oe = state_q inside {START_B, STOP_A, STOP_B} || (state_q == BIT && bit_sda);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= DIV_WIDTH'(DIV_RESET);
         tx_q <= '0;
         rx_q <= '0;
         cmd_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         nack_q <= 1'b0;
         readdata_q <= '0;
      end else begin
         if (wr && address == 2'd0 && !busy_q) tx_q <= writedata[7:0];
         if (wr && address == 2'd3 && !busy_q) div_q <= writedata[DIV_WIDTH-1:0];
         if (go) cmd_q <= writedata[3:0];
         busy_q <= go ? 1'b1 : fin ? 1'b0 : busy_q;
         done_q <= fin || (done_q && !(wr && address == 2'd2));
         if (samp && bit_q != 4'd0 && cmd_q[2]) rx_q <= {rx_q[6:0], sda_in};
         if (samp && bit_q == 4'd0 && !cmd_q[2]) nack_q <= sda_in;
         readdata_q <= readdata_d;
      end
   end
   always_comb begin
      readdata_d = address == 2'd0 ? {24'b0, rx_q} :
                   address == 2'd1 ? {26'b0, ie_q, 1'b0, cmd_q} :
                   address == 2'd2 ? {29'b0, done_q, nack_q, busy_q} : 32'(div_q);
   end
`ifdef I2C_MASTER_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ie_q <= 1'b0;
      else if (wr && address == 2'd1) ie_q <= writedata[5];
   end
   assign irq = done_q && ie_q;
`else
   assign ie_q = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// tb_i2c_master_byte_engine: register-read and I2C bus-event scoreboards with an open-drain slave model.
module tb_i2c_master_byte_engine;
   logic clk = 0, reset = 1;
   logic [1:0] address = 0;
   logic chipselect = 0, write_n = 1;
   logic [31:0] writedata = 0;
   logic [31:0] readdata;
   logic scl_oe, sda_oe, scl_in, sda_in;
`ifdef I2C_MASTER_IRQ_EN
   logic irq;
`endif
   logic slv_scl_low = 0, slv_sda_low = 0;
   assign scl_in = !(scl_oe || slv_scl_low);
   assign sda_in = !(sda_oe || slv_sda_low);

   i2c_master_byte_engine dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .scl_oe(scl_oe), .sda_oe(sda_oe),
`ifdef I2C_MASTER_IRQ_EN
      .irq(irq),
`endif
      .scl_in(scl_in), .sda_in(sda_in)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int ev_q[$];
   logic [31:0] rd_exp[$];
   string rd_nm[$];
   logic rd_req = 0, rd_vld = 0;
   logic pscl = 1, psda = 1, mon_en = 0, hi_valid = 0, slv_str = 0;
   logic [7:0] sh = 0, slv_byte = 0;
   int nb = 0, hi_cnt = 0, lo_cnt = 0, hi_min = 0, hi_max = 0, lo_max = 0;
   int slv_mode = 0, rises = 0, scnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // bus events: 256 START, 257 STOP, 0..255 byte, 512+level for the ACK slot
   task automatic emit(input int v);
      if (!mon_en) return;
      if (ev_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL bus_unexpected: actual=0x%0h required=none", v);
      end else chk("bus_event", v, ev_q.pop_front());
   endtask

   always @(posedge clk) rd_vld <= rd_req;

   always @(negedge clk) begin
      logic scl, sda;
      scl = scl_in;
      sda = sda_in;
      if (rd_vld) begin
         if (rd_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: actual=0x%0h required=none", readdata);
         end else chk(rd_nm.pop_front(), readdata, rd_exp.pop_front());
      end
      if (pscl && scl && psda && !sda) begin
         emit(256);
         nb = 0;
         rises = 0;
      end else if (pscl && scl && !psda && sda) begin
         emit(257);
         nb = 0;
      end else if (!pscl && scl) begin
         if (nb < 8) begin
            sh = {sh[6:0], sda};
            nb++;
            if (nb == 8) emit(int'(sh));
         end else if (nb == 8) begin
            emit(512 + int'(sda));
            nb = 9;
         end
      end
      if (!pscl && scl) begin
         if (lo_cnt > lo_max) lo_max = lo_cnt;
         hi_cnt = 1;
         hi_valid = 1;
      end else if (pscl && !scl) begin
         if (hi_valid) begin
            if (hi_cnt < hi_min) hi_min = hi_cnt;
            if (hi_cnt > hi_max) hi_max = hi_cnt;
         end
         lo_cnt = 1;
      end else if (scl) hi_cnt++;
      else lo_cnt++;
      if (scnt > 0) begin
         scnt--;
         if (scnt == 10) slv_sda_low = !slv_byte[3];
         if (scnt == 0) slv_scl_low = 0;
      end
      if (!pscl && scl) rises++;
      if (pscl && !scl) begin
         if (slv_mode == 2) begin
            slv_sda_low = rises < 8 ? !slv_byte[7-rises] : 1'b0;
            if (slv_str && rises == 4) begin
               slv_scl_low = 1;
               slv_sda_low = slv_byte[3];
               scnt = 1000;
            end
         end else if (slv_mode == 1) begin
            if (rises == 8) slv_sda_low = 1;
            else if (rises == 9) begin
               slv_sda_low = 0;
               slv_mode = 0;
            end
         end
      end
      pscl = scl;
      psda = sda;
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a;
      writedata = d;
      chipselect = 1;
      write_n = 0;
      @(negedge clk);
      chipselect = 0;
      write_n = 1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      address = a;
      rd_exp.push_back(exp);
      rd_nm.push_back(nm);
      rd_req = 1;
      @(negedge clk);
      rd_req = 0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      address = 2;
      @(negedge clk);
      @(negedge clk);
      while (readdata[0] && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_busy_timeout"}, {31'b0, readdata[0]}, 0);
   endtask

   task automatic arm(input int m, input logic [7:0] b, input logic s);
      slv_mode = m;
      slv_byte = b;
      slv_str = s;
      rises = 0;
   endtask

   task automatic trk_clr();
      hi_valid = 0;
      hi_min = 1 << 30;
      hi_max = 0;
      lo_max = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);
      // reset in the middle of a byte
      wr(0, 'h5A);
      wr(1, 'h11);
      repeat (1400) @(negedge clk);
      reset = 1;
      #1;
      chk("rst_scl_oe", {31'b0, scl_oe}, 0);
      chk("rst_sda_oe", {31'b0, sda_oe}, 0);
      @(negedge clk);
      reset = 0;
      rd(2, 'h0, "rst_status");
      rd(3, 124, "rst_div");
      rd(0, 'h0, "rst_rx");
      rd(1, 'h0, "rst_cmd");
      mon_en = 1;
      // write 0xA5 with START and STOP, slave ACKs
      trk_clr();
      ev_q.push_back(256); ev_q.push_back('hA5); ev_q.push_back(512); ev_q.push_back(257);
      arm(1, 0, 0);
      wr(0, 'hA5);
      wr(1, 'h13);
      wait_idle("wr_a5");
      chk("scl_high_min", hi_min, 250);
      chk("scl_high_max", hi_max, 250);
      rd(2, 'h4, "wr_a5_status");
      rd(1, 'h3, "wr_a5_cmd");
      wr(2, 0);
      rd(2, 'h0, "done_clear");
      // read with master NACK, no STOP
      ev_q.push_back('h3C); ev_q.push_back(513);
      arm(2, 'h3C, 0);
      wr(1, 'h1C);
      wait_idle("rd_3c");
      rd(0, 'h3C, "rd_3c_data");
      rd(2, 'h4, "rd_3c_status");
      rd(1, 'hC, "rd_3c_cmd");
      chk("rd_3c_scl_held", {31'b0, scl_oe}, 1);
      chk("rd_3c_sda_free", {31'b0, sda_oe}, 0);
      wr(2, 0);
      // write 0x55 without slave ACK; writes during BUSY must be dropped
      ev_q.push_back(256); ev_q.push_back('h55); ev_q.push_back(513); ev_q.push_back(257);
      arm(0, 0, 0);
      wr(0, 'h55);
      wr(1, 'h13);
      wr(0, 'hFF);
      wr(1, 'h11);
      wr(3, 5);
      wait_idle("wr_55");
      rd(2, 'h6, "wr_55_status");
      rd(1, 'h3, "busy_go_ignored");
      rd(3, 124, "busy_div_ignored");
      wr(2, 0);
      // repeat without a DATA write: TX must still be 0x55
      ev_q.push_back(256); ev_q.push_back('h55); ev_q.push_back(512); ev_q.push_back(257);
      arm(1, 0, 0);
      wr(1, 'h13);
      wait_idle("tx_kept");
      rd(2, 'h4, "tx_kept_status");
      wr(2, 0);
      // clock stretch on bit 5 with wrong SDA while SCL is held low
      trk_clr();
      ev_q.push_back('h96); ev_q.push_back(512);
      arm(2, 'h96, 1);
      wr(1, 'h14);
      wait_idle("stretch");
      rd(0, 'h96, "stretch_data");
      chk("stretch_low_time", {31'b0, lo_max >= 1000}, 1);
      rd(2, 'h4, "stretch_status");
      wr(2, 0);
      // DIV = 0: one clk per quarter
      wr(3, 0);
      rd(3, 0, "div0_read");
      ev_q.push_back(256); ev_q.push_back('hC3); ev_q.push_back(512); ev_q.push_back(257);
      arm(1, 0, 0);
      wr(0, 'hC3);
      wr(1, 'h13);
      wait_idle("div0");
      rd(2, 'h4, "div0_status");
      wr(2, 0);
`ifdef I2C_MASTER_IRQ_EN
      ev_q.push_back('hC3); ev_q.push_back(513);
      arm(0, 0, 0);
      wr(1, 'h30);
      wait_idle("irq");
      chk("irq_set", {31'b0, irq}, 1);
      rd(1, 'h20, "irq_cmd_ie");
      wr(2, 0);
      chk("irq_clear", {31'b0, irq}, 0);
`endif
      repeat (20) @(negedge clk);
      chk("bus_events_left", ev_q.size(), 0);
      chk("reads_left", rd_exp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
